segment_capture: RTL and testbench

SEGMENT_CAPTURE -- requirements
Module: segment_capture

---
 rtl/segment_capture.sv | 174 +++++++++++++++++
 tb/tb_segment_capture.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_capture.sv
// segment_capture: rebuilds a 4-digit BCD frame by sampling a multiplexed, active-low 7-segment bus.
// Optional macro SEGMENT_CAPTURE_STABLE_FILTER_EN: a digit needs 3 identical samples before it is accepted.
module segment_capture (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  input  logic        frame_ack,
  output logic [15:0] bcd,
  output logic [3:0]  minus,
  output logic        frame_valid,
  output logic        overrun,
  output logic        err
);

`ifdef SEGMENT_CAPTURE_STABLE_FILTER_EN
  localparam logic [1:0] STABLE_N = 2'd3;
`else
  localparam logic [1:0] STABLE_N = 2'd1;
`endif

  typedef enum logic {WAIT0, CAP} state_t;

  state_t      r_state;
  logic [1:0]  r_nxt;
  logic [1:0]  r_cnt;
  logic [11:0] r_shadow_bcd;
  logic [2:0]  r_shadow_minus;
  logic [3:0]  r_last_an;
  logic [6:0]  r_last_seg;
  logic        r_taken;

  logic [3:0]  w_an_n;
  logic        w_an_legal;
  logic        w_new_act;
  logic        w_same;
  logic        w_taken;
  logic        w_qual;
  logic [1:0]  w_digit;
  logic [1:0]  w_cnt_next;
  logic        w_pat_ok;
  logic        w_pat_minus;
  logic [3:0]  w_pat_nib;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_pat_ok    = 1'b1;
    w_pat_minus = 1'b0;
    w_pat_nib   = 4'h0;
    case (seg)
      7'b0000001: w_pat_nib = 4'd0;
      7'b1001111: w_pat_nib = 4'd1;
      7'b0010010: w_pat_nib = 4'd2;
      7'b0000110: w_pat_nib = 4'd3;
      7'b1001100: w_pat_nib = 4'd4;
      7'b0100100: w_pat_nib = 4'd5;
      7'b0100000: w_pat_nib = 4'd6;
      7'b0001111: w_pat_nib = 4'd7;
      7'b0000000: w_pat_nib = 4'd8;
      7'b0000100: w_pat_nib = 4'd9;
      7'b1111110: begin
        w_pat_nib   = 4'hF;
        w_pat_minus = 1'b1;
      end
      default: w_pat_ok = 1'b0;
    endcase

    w_digit = 2'd0;
    case (an)
      4'b1101: w_digit = 2'd1;
      4'b1011: w_digit = 2'd2;
      4'b0111: w_digit = 2'd3;
      default: w_digit = 2'd0;
    endcase

    // Legal non-blank anode word has exactly one low bit.
    w_an_n     = ~an;
    w_an_legal = (an != 4'hF) && ((w_an_n & (w_an_n - 4'd1)) == 4'd0);
    w_new_act  = (an != r_last_an);
    w_same     = !w_new_act && (seg == r_last_seg);
    w_cnt_next = !w_same ? 2'd1 : ((r_cnt == 2'd3) ? 2'd3 : r_cnt + 2'd1);
    w_taken    = r_taken && !w_new_act;
    w_qual     = ce && w_an_legal && (w_cnt_next >= STABLE_N) && !w_taken;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= WAIT0;
      r_nxt          <= 2'd0;
      r_cnt          <= 2'd0;
      r_shadow_bcd   <= 12'h000;
      r_shadow_minus <= 3'b000;
      r_last_an      <= 4'hF;
      r_last_seg     <= 7'h7F;
      r_taken        <= 1'b0;
      bcd            <= 16'h0000;
      minus          <= 4'b0000;
      frame_valid    <= 1'b0;
      overrun        <= 1'b0;
      err            <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values; later writes win.
      err     <= 1'b0;
      overrun <= 1'b0;
      if (frame_ack && frame_valid)
        frame_valid <= 1'b0;

      if (ce && an != 4'hF) begin
        if (!w_an_legal) begin
          err        <= 1'b1;
          r_state    <= WAIT0;
          r_cnt      <= 2'd0;
          r_last_an  <= 4'hF;
          r_last_seg <= 7'h7F;
          r_taken    <= 1'b0;
        end else begin
          r_last_an  <= an;
          r_last_seg <= seg;
          r_cnt      <= w_cnt_next;
          r_taken    <= w_taken | w_qual;
          if (w_qual) begin
            case (r_state)
              WAIT0: begin
                if (w_digit == 2'd0) begin
                  if (!w_pat_ok) begin
                    err <= 1'b1;
                  end else begin
                    r_shadow_bcd[3:0] <= w_pat_nib;
                    r_shadow_minus[0] <= w_pat_minus;
                    r_nxt             <= 2'd1;
                    r_state           <= CAP;
                  end
                end
              end
              CAP: begin
                if (w_digit == r_nxt) begin
                  if (!w_pat_ok) begin
                    err     <= 1'b1;
                    r_state <= WAIT0;
                  end else if (r_nxt == 2'd3) begin
                    bcd         <= {w_pat_nib, r_shadow_bcd};
                    minus       <= {w_pat_minus, r_shadow_minus};
                    frame_valid <= 1'b1;
                    overrun     <= frame_valid && !frame_ack;
                    r_state     <= WAIT0;
                  end else begin
                    case (r_nxt)
                      2'd1: begin
                        r_shadow_bcd[7:4] <= w_pat_nib;
                        r_shadow_minus[1] <= w_pat_minus;
                      end
                      2'd2: begin
                        r_shadow_bcd[11:8] <= w_pat_nib;
                        r_shadow_minus[2]  <= w_pat_minus;
                      end
                      default: ;
                    endcase
                    r_nxt <= r_nxt + 2'd1;
                  end
                end else if (w_digit != r_nxt - 2'd1) begin
                  err     <= 1'b1;
                  r_state <= WAIT0;
                end
              end
              default: r_state <= WAIT0;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_segment_capture.sv
// Self-checking bench for segment_capture: directed table, corner sequences, randomized run vs reference model.
module tb_segment_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_ack;
  logic [15:0] bcd;
  logic [3:0]  minus;
  logic        frame_valid;
  logic        overrun;
  logic        err;

  segment_capture dut (
    .clk(clk), .rst(rst), .ce(ce), .seg(seg), .an(an), .frame_ack(frame_ack),
    .bcd(bcd), .minus(minus), .frame_valid(frame_valid), .overrun(overrun), .err(err)
  );

  always #5 clk = ~clk;

`ifdef SEGMENT_CAPTURE_STABLE_FILTER_EN
  localparam int HOLD = 3;
`else
  localparam int HOLD = 1;
`endif

  // Digit patterns 0..9, index 10 is the minus sign.
  localparam logic [6:0] PAT [11] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
    7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b1111110 };
  localparam logic [3:0] AN_SEL [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (bcd,minus,fv,ov,err packed)", name, act, exp);
    end
  endtask

  // Reference model: digits collected into an array, frame assembled arithmetically.
  int          m_next;
  int          m_val [4];
  bit          m_neg [4];
  int          m_run;
  bit          m_used;
  logic [3:0]  m_prev_an;
  logic [6:0]  m_prev_seg;
  logic [15:0] m_bcd;
  logic [3:0]  m_minus;
  bit          m_fv, m_ov, m_err;

  function automatic void model_reset();
    m_next = -1; m_run = 0; m_used = 0; m_prev_an = 4'hF; m_prev_seg = 7'h7F;
    m_bcd = 16'h0; m_minus = 4'h0; m_fv = 0; m_ov = 0; m_err = 0;
    for (int i = 0; i < 4; i++) begin m_val[i] = 0; m_neg[i] = 0; end
  endfunction

  function automatic void model_step(input logic c, input logic [3:0] a, input logic [6:0] s, input logic k);
    int d, zeros, val;
    bit neg, legal_pat, was_valid;
    was_valid = m_fv;
    m_err = 0;
    m_ov  = 0;
    if (k && m_fv) m_fv = 0;
    if (!c || a == 4'hF) return;
    zeros = 0; d = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) begin zeros++; d = i; end
    if (zeros != 1) begin
      m_err = 1; m_next = -1; m_run = 0; m_used = 0; m_prev_an = 4'hF; m_prev_seg = 7'h7F;
      return;
    end
    if (a == m_prev_an && s == m_prev_seg) m_run++; else m_run = 1;
    if (a != m_prev_an) m_used = 0;
    m_prev_an = a; m_prev_seg = s;
    if (m_run < HOLD || m_used) return;
    m_used = 1;
    legal_pat = 0; val = 0; neg = 0;
    for (int i = 0; i < 11; i++)
      if (s == PAT[i]) begin legal_pat = 1; val = (i == 10) ? 15 : i; neg = (i == 10); end
    if (m_next < 0) begin
      if (d != 0) return;
      if (!legal_pat) begin m_err = 1; return; end
      m_val[0] = val; m_neg[0] = neg; m_next = 1;
    end else if (d == m_next) begin
      if (!legal_pat) begin m_err = 1; m_next = -1; return; end
      m_val[d] = val; m_neg[d] = neg;
      if (d == 3) begin
        m_bcd   = 16'(m_val[3] * 4096 + m_val[2] * 256 + m_val[1] * 16 + m_val[0]);
        m_minus = {m_neg[3], m_neg[2], m_neg[1], m_neg[0]};
        m_ov    = was_valid && !k;
        m_fv    = 1;
        m_next  = -1;
      end else m_next++;
    end else if (d != m_next - 1) begin
      m_err = 1; m_next = -1;
    end
  endfunction

  function automatic logic [31:0] dut_pack();
    return {9'd0, bcd, minus, frame_valid, overrun, err};
  endfunction

  function automatic logic [31:0] model_pack();
    return {9'd0, m_bcd, m_minus, m_fv, m_ov, m_err};
  endfunction

  task automatic cycle(input logic c, input logic [3:0] a, input logic [6:0] s, input logic k);
    ce = c; an = a; seg = s; frame_ack = k;
    model_step(c, a, s, k);
    @(posedge clk); #1;
  endtask

  task automatic hold_chk(input string name, input logic [3:0] a, input logic [6:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, a, s, 1'b0);
      check(name, dut_pack(), model_pack());
    end
  endtask

  typedef struct {
    string       name;
    logic        c;
    logic [3:0]  a;
    logic [6:0]  s;
    logic        k;
    logic [15:0] e_bcd;
    logic [3:0]  e_minus;
    logic        e_fv, e_ov, e_err;
  } vec_t;

  vec_t tbl [$];

  function automatic void add(input string nm, input logic c, input logic [3:0] a, input logic [6:0] s,
                              input logic k, input logic [15:0] b, input logic [3:0] m,
                              input logic fv, input logic ov, input logic er);
    vec_t v;
    v.name = nm; v.c = c; v.a = a; v.s = s; v.k = k;
    v.e_bcd = b; v.e_minus = m; v.e_fv = fv; v.e_ov = ov; v.e_err = er;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [3:0] ra;
    logic [6:0] rs;
    logic       rc, rk;
    int         pos, hold, r, reps;
    logic [15:0] glitch_exp;

    rst = 1'b1; ce = 1'b0; an = 4'hF; seg = 7'h7F; frame_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", dut_pack(), 32'h0);
    rst = 1'b0;

    // Basic scan, minus digit, illegal pattern, overrun, coincident ack, scan-order and anode errors.
    add("scan_d0",   1, 4'hE, PAT[1],  0, 16'h0000, 4'b0000, 0, 0, 0);
    add("scan_d1",   1, 4'hD, PAT[2],  0, 16'h0000, 4'b0000, 0, 0, 0);
    add("scan_d2",   1, 4'hB, PAT[3],  0, 16'h0000, 4'b0000, 0, 0, 0);
    add("scan_done", 1, 4'h7, PAT[4],  0, 16'h4321, 4'b0000, 1, 0, 0);
    add("scan_ack",  0, 4'hF, 7'h7F,   1, 16'h4321, 4'b0000, 0, 0, 0);
    add("neg_d0",    1, 4'hE, PAT[5],  0, 16'h4321, 4'b0000, 0, 0, 0);
    add("neg_d1",    1, 4'hD, PAT[5],  0, 16'h4321, 4'b0000, 0, 0, 0);
    add("neg_d2",    1, 4'hB, PAT[10], 0, 16'h4321, 4'b0000, 0, 0, 0);
    add("neg_done",  1, 4'h7, PAT[5],  0, 16'h5F55, 4'b0100, 1, 0, 0);
    add("neg_ack",   0, 4'hF, 7'h7F,   1, 16'h5F55, 4'b0100, 0, 0, 0);
    add("bad_d0",    1, 4'hE, PAT[1],  0, 16'h5F55, 4'b0100, 0, 0, 0);
    add("bad_pat",   1, 4'hD, 7'h7F,   0, 16'h5F55, 4'b0100, 0, 0, 1);
    add("bad_skip2", 1, 4'hB, PAT[2],  0, 16'h5F55, 4'b0100, 0, 0, 0);
    add("bad_skip3", 1, 4'h7, PAT[3],  0, 16'h5F55, 4'b0100, 0, 0, 0);
    add("rec_d0",    1, 4'hE, PAT[6],  0, 16'h5F55, 4'b0100, 0, 0, 0);
    add("rec_d1",    1, 4'hD, PAT[7],  0, 16'h5F55, 4'b0100, 0, 0, 0);
    add("rec_d2",    1, 4'hB, PAT[8],  0, 16'h5F55, 4'b0100, 0, 0, 0);
    add("rec_done",  1, 4'h7, PAT[9],  0, 16'h9876, 4'b0000, 1, 0, 0);
    add("rec_ack",   0, 4'hF, 7'h7F,   1, 16'h9876, 4'b0000, 0, 0, 0);
    add("f1_d0",     1, 4'hE, PAT[1],  0, 16'h9876, 4'b0000, 0, 0, 0);
    add("f1_d1",     1, 4'hD, PAT[2],  0, 16'h9876, 4'b0000, 0, 0, 0);
    add("f1_d2",     1, 4'hB, PAT[3],  0, 16'h9876, 4'b0000, 0, 0, 0);
    add("f1_done",   1, 4'h7, PAT[4],  0, 16'h4321, 4'b0000, 1, 0, 0);
    add("f2_d0",     1, 4'hE, PAT[5],  0, 16'h4321, 4'b0000, 1, 0, 0);
    add("f2_d1",     1, 4'hD, PAT[6],  0, 16'h4321, 4'b0000, 1, 0, 0);
    add("f2_d2",     1, 4'hB, PAT[7],  0, 16'h4321, 4'b0000, 1, 0, 0);
    add("f2_ovr",    1, 4'h7, PAT[8],  0, 16'h8765, 4'b0000, 1, 1, 0);
    add("f3_d0",     1, 4'hE, PAT[9],  0, 16'h8765, 4'b0000, 1, 0, 0);
    add("f3_d1",     1, 4'hD, PAT[0],  0, 16'h8765, 4'b0000, 1, 0, 0);
    add("f3_d2",     1, 4'hB, PAT[1],  0, 16'h8765, 4'b0000, 1, 0, 0);
    add("f3_ackcmp", 1, 4'h7, PAT[2],  1, 16'h2109, 4'b0000, 1, 0, 0);
    add("f3_ack",    0, 4'hF, 7'h7F,   1, 16'h2109, 4'b0000, 0, 0, 0);
    add("ord_d0",    1, 4'hE, PAT[1],  0, 16'h2109, 4'b0000, 0, 0, 0);
    add("ord_jump",  1, 4'hB, PAT[2],  0, 16'h2109, 4'b0000, 0, 0, 1);
    add("ord_wait",  1, 4'hD, PAT[3],  0, 16'h2109, 4'b0000, 0, 0, 0);
    add("an_2hot",   1, 4'hC, PAT[1],  0, 16'h2109, 4'b0000, 0, 0, 1);
    add("an_blank",  1, 4'hF, PAT[1],  0, 16'h2109, 4'b0000, 0, 0, 0);

    foreach (tbl[i]) begin
      reps = tbl[i].c ? HOLD : 1;
      for (int j = 0; j < reps; j++) cycle(tbl[i].c, tbl[i].a, tbl[i].s, tbl[i].k);
      check(tbl[i].name, dut_pack(),
            {9'd0, tbl[i].e_bcd, tbl[i].e_minus, tbl[i].e_fv, tbl[i].e_ov, tbl[i].e_err});
    end

    // Short glitch on digit 1: rejected by the filter, taken as-is without it.
    hold_chk("gl_d0", 4'hE, PAT[1], HOLD);
    hold_chk("gl_glitch", 4'hD, PAT[5], 2);
    hold_chk("gl_d1", 4'hD, PAT[2], HOLD);
    hold_chk("gl_d2", 4'hB, PAT[3], HOLD);
    hold_chk("gl_d3", 4'h7, PAT[4], HOLD);
`ifdef SEGMENT_CAPTURE_STABLE_FILTER_EN
    glitch_exp = 16'h4321;
`else
    glitch_exp = 16'h4351;
`endif
    check("gl_frame", dut_pack(), {9'd0, glitch_exp, 4'b0000, 1'b1, 1'b0, 1'b0});

    // Asynchronous reset in the middle of a scan, then a partial scan that must not complete.
    hold_chk("rs_d0", 4'hE, PAT[1], HOLD);
    hold_chk("rs_d1", 4'hD, PAT[2], HOLD);
    rst = 1'b1;
    #1;
    check("rst_async", dut_pack(), 32'h0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    hold_chk("rs_p2", 4'hB, PAT[3], HOLD);
    hold_chk("rs_p3", 4'h7, PAT[4], HOLD);
    check("rs_nofrm", dut_pack(), 32'h0);
    hold_chk("rs_f0", 4'hE, PAT[5], HOLD);
    hold_chk("rs_f1", 4'hD, PAT[6], HOLD);
    hold_chk("rs_f2", 4'hB, PAT[7], HOLD);
    hold_chk("rs_f3", 4'h7, PAT[8], HOLD);
    check("rs_frame", dut_pack(), {9'd0, 16'h8765, 4'b0000, 1'b1, 1'b0, 1'b0});

    // Randomized scanning with blanks, glitches, bad patterns, stray anodes and random acks.
    pos = 3; hold = 0; ra = 4'hF; rs = 7'h7F;
    for (int n = 0; n < 3000; n++) begin
      if (hold == 0) begin
        r = $urandom_range(0, 99);
        if (r < 80) begin
          pos = (pos + 1) % 4;
          ra  = AN_SEL[pos];
        end else if (r < 90) ra = 4'hF;
        else if (r < 95) ra = AN_SEL[$urandom_range(0, 3)];
        else ra = 4'($urandom);
        rs   = ($urandom_range(0, 9) == 0) ? 7'($urandom) : PAT[$urandom_range(0, 10)];
        hold = $urandom_range(1, HOLD + 2);
      end else if ($urandom_range(0, 19) == 0) begin
        rs = PAT[$urandom_range(0, 10)];
      end
      hold--;
      rc = ($urandom_range(0, 3) != 0);
      rk = ($urandom_range(0, 3) == 0);
      cycle(rc, ra, rs, rk);
      check("rand", dut_pack(), model_pack());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
